pcie_tx_arbiter: RTL and testbench
==================================

Name: pcie_tx_arbiter

Overview:
- Shares the single PCIe endpoint AXIS TX port (64-bit, 8-bit tkeep) between two TLP sources.
- Source 0 is the completion/PIO engine; source 1 is the snoop/forwarding engine.
- Arbitration is packet-granular round-robin: once a source is granted, it owns the port until its tlast.
- A per-packet stall watchdog terminates a hung TLP with tx_src_dsc, then drains the offending source's remaining beats.

Parameters:
- TIMEOUT, 255: cycles a granted source may hold tvalid low mid-packet before abort. Valid range 1..65535.

Ports:
- clk  in  1  user clock for all logic.
- sys_rst  in  1  synchronous, active-high reset.
- s0_tdata  in  64  source 0 TLP data.
- s0_tkeep  in  8  source 0 byte enables.
- s0_tlast  in  1  source 0 end of packet.
- s0_tvalid  in  1  source 0 beat valid.
- s0_tready  out  1  source 0 beat accepted.
- s1_tdata, s1_tkeep, s1_tlast, s1_tvalid, s1_tready: same widths and directions as the source 0 signals.
- s_axis_tx_tready  in  1  core ready.
- s_axis_tx_tdata  out  64  data to core.
- s_axis_tx_tkeep  out  8  byte enables to core.
- s_axis_tx_tlast  out  1  end of packet to core.
- s_axis_tx_tvalid  out  1  beat valid to core.
- tx_src_dsc  out  1  source discontinue to core.
- grant  out  2  one-hot current owner; 2'b00 when unowned.
- tlp_pktcount  out  8  completed TLPs sent, wrapping.
- abort_count  out  8  watchdog aborts, saturating at 8'hFF.

Behaviour:
- States: IDLE, BUSY0, BUSY1, ABORT, DRAIN0, DRAIN1.
- Registered state: state, rr_last (last served source), stall counter (16 bits), tlp_pktcount, abort_count, abort_src.
- On reset (any state, including mid-packet):
  - state=IDLE, rr_last=1 (so source 0 wins the first tie), stall counter=0, both counters=0.
  - Outputs during reset and in IDLE: s_axis_tx_tvalid=0, tdata=0, tkeep=0, tlast=0, tx_src_dsc=0, s0_tready=0, s1_tready=0, grant=0.
- IDLE:
  - Only s0_tvalid → BUSY0. Only s1_tvalid → BUSY1.
  - Both valid → grant the source that is not rr_last.
  - No beat is forwarded in the arbitration cycle: 1-cycle grant latency.
- BUSYn:
  - Datapath is a combinational pass-through: s_axis_tx_{tdata,tkeep,tlast,tvalid} = sn_*; sn_tready = s_axis_tx_tready.
  - Other source: tready=0. tx_src_dsc=0. grant one-hot n.
  - Beat accepted = sn_tvalid & s_axis_tx_tready.
  - Accepted beat with tlast → IDLE, rr_last=n, tlp_pktcount+1 (8'hFF wraps to 8'h00).
  - Stall counter clears on entry and on every cycle with sn_tvalid=1.
  - Stall counter increments each cycle with sn_tvalid=0.
  - Stall counter reaches TIMEOUT while sn_tvalid=0 → ABORT, abort_src=n, abort_count+1 (saturating).
  - tvalid=1 with tready=0 is backpressure, not a stall.
- ABORT:
  - Drive s_axis_tx_tvalid=1, tlast=1, tx_src_dsc=1, tdata=0, tkeep=8'hFF.
  - Both source treadys=0.
  - Hold these values until s_axis_tx_tready=1, then → DRAINn for n=abort_src.
  - tlp_pktcount is not incremented for an aborted TLP.
- DRAINn:
  - sn_tready=1. Core outputs idle (tvalid=0). grant=0.
  - Beats from source n are discarded.
  - An accepted beat with tlast → IDLE, rr_last=n.
  - The other source waits.
- A single-beat packet (tvalid and tlast on the first beat) completes in one BUSY cycle.
- In BUSYn, tvalid from the non-granted source is ignored; it is not lost, because its tready stays 0.
- Throughput: back-to-back packets from the same source incur exactly 1 idle cycle between tlast and the next first beat.

Test Plan:
- Only s0 sends a 3-beat TLP, core tready=1 → grant=01 one cycle after tvalid; 3 beats forwarded unchanged; tlp_pktcount 0→1; then IDLE.
- s0 and s1 both hold 2-beat TLPs from reset → s0 sent first, then s1, then s0 again; grant sequence 01,00,10,00,01.
- Core tready toggles 1,0,0,1 during a s1 4-beat packet → no beat duplicated or dropped; s1_tready mirrors core tready; stall counter stays 0.
- TIMEOUT=4; s0 sends 1 beat then holds tvalid low → after 4 stalled cycles the core sees one beat with tvalid=1, tlast=1, tx_src_dsc=1, tkeep=FF.
  - abort_count=1; tlp_pktcount unchanged.
  - s0's later 2 beats are drained with s0_tready=1 and never reach the core.
- sys_rst asserted on the second beat of a s1 packet → next cycle all outputs 0, counters 0; the first post-reset tie grants s0.
- 256 single-beat TLPs from s1 → tlp_pktcount wraps to 8'h00; 1 idle cycle between every pair of packets.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one 64-bit AXIS PCIe TX port between
// source 0 (completion/PIO) and source 1 (snoop/forwarding). A per-packet stall
// watchdog terminates a hung TLP with tx_src_dsc and then drains the offending source.
module pcie_tx_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [63:0] s0_tdata,
  input  logic [7:0]  s0_tkeep,
  input  logic        s0_tlast,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [63:0] s1_tdata,
  input  logic [7:0]  s1_tkeep,
  input  logic        s1_tlast,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic        s_axis_tx_tready,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  output logic        tx_src_dsc,
  output logic [1:0]  grant,
  output logic [7:0]  tlp_pktcount,
  output logic [7:0]  abort_count
);

  typedef enum logic [2:0] {
    StIdle,
    StBusy0,
    StBusy1,
    StAbort,
    StDrain0,
    StDrain1
  } state_e;

  // Abort fires on the cycle the counter would reach TIMEOUT.
  localparam logic [15:0] StallLimit = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  logic [15:0] stall_q, stall_d;
  logic [7:0]  pktcount_q, pktcount_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;
  logic        abort_src_q, abort_src_d;

  // Source selected by the current BUSY/DRAIN state.
  logic cur_src;
  logic cur_valid;
  logic cur_last;

  assign cur_src   = (state_q == StBusy1) || (state_q == StDrain1);
  assign cur_valid = cur_src ? s1_tvalid : s0_tvalid;
  assign cur_last  = cur_src ? s1_tlast : s0_tlast;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      rr_last_q   <= 1'b1;
      stall_q     <= '0;
      pktcount_q  <= '0;
      abort_cnt_q <= '0;
      abort_src_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      stall_q     <= stall_d;
      pktcount_q  <= pktcount_d;
      abort_cnt_q <= abort_cnt_d;
      abort_src_q <= abort_src_d;
    end
  end

  // Next-state: arbitration, packet completion, stall watchdog and drain.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    stall_d     = stall_q;
    pktcount_d  = pktcount_q;
    abort_cnt_d = abort_cnt_q;
    abort_src_d = abort_src_q;
    case (state_q)
      StIdle: begin
        stall_d = '0;
        // On a tie, serve the source that did not go last.
        if (s0_tvalid && (!s1_tvalid || rr_last_q)) begin
          state_d = StBusy0;
        end else if (s1_tvalid) begin
          state_d = StBusy1;
        end
      end
      StBusy0, StBusy1: begin
        if (cur_valid) begin
          // Backpressure is not a stall.
          stall_d = '0;
          if (s_axis_tx_tready && cur_last) begin
            state_d    = StIdle;
            rr_last_d  = cur_src;
            pktcount_d = pktcount_q + 8'd1;
          end
        end else if (stall_q == StallLimit) begin
          state_d     = StAbort;
          stall_d     = '0;
          abort_src_d = cur_src;
          if (abort_cnt_q != 8'hFF) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
          end
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      StAbort: begin
        if (s_axis_tx_tready) begin
          state_d = abort_src_q ? StDrain1 : StDrain0;
        end
      end
      StDrain0, StDrain1: begin
        // tready is forced high here, so a valid beat is always consumed.
        if (cur_valid && cur_last) begin
          state_d   = StIdle;
          rr_last_d = cur_src;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output mux: pass-through while busy, discontinue beat on abort, sink while draining.
  always_comb begin
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    tx_src_dsc       = 1'b0;
    s0_tready        = 1'b0;
    s1_tready        = 1'b0;
    grant            = 2'b00;
    if (!sys_rst) begin
      case (state_q)
        StBusy0: begin
          s_axis_tx_tdata  = s0_tdata;
          s_axis_tx_tkeep  = s0_tkeep;
          s_axis_tx_tlast  = s0_tlast;
          s_axis_tx_tvalid = s0_tvalid;
          s0_tready        = s_axis_tx_tready;
          grant            = 2'b01;
        end
        StBusy1: begin
          s_axis_tx_tdata  = s1_tdata;
          s_axis_tx_tkeep  = s1_tkeep;
          s_axis_tx_tlast  = s1_tlast;
          s_axis_tx_tvalid = s1_tvalid;
          s1_tready        = s_axis_tx_tready;
          grant            = 2'b10;
        end
        StAbort: begin
          s_axis_tx_tkeep  = 8'hFF;
          s_axis_tx_tlast  = 1'b1;
          s_axis_tx_tvalid = 1'b1;
          tx_src_dsc       = 1'b1;
        end
        StDrain0: s0_tready = 1'b1;
        StDrain1: s1_tready = 1'b1;
        default: ;
      endcase
    end
  end

  assign tlp_pktcount = pktcount_q;
  assign abort_count  = abort_cnt_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter: single source, round-robin tie, backpressure,
// watchdog abort and drain, mid-packet reset and packet counter wrap.
module tb_pcie_tx_arbiter;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [63:0] s0_tdata, s1_tdata;
  logic [7:0]  s0_tkeep, s1_tkeep;
  logic        s0_tlast, s1_tlast, s0_tvalid, s1_tvalid;
  logic        s0_tready, s1_tready;
  logic        s_axis_tx_tready;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast, s_axis_tx_tvalid, tx_src_dsc;
  logic [1:0]  grant;
  logic [7:0]  tlp_pktcount, abort_count;

  int checks = 0;
  int errors = 0;

  pcie_tx_arbiter #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .sys_rst          (sys_rst),
    .s0_tdata         (s0_tdata),
    .s0_tkeep         (s0_tkeep),
    .s0_tlast         (s0_tlast),
    .s0_tvalid        (s0_tvalid),
    .s0_tready        (s0_tready),
    .s1_tdata         (s1_tdata),
    .s1_tkeep         (s1_tkeep),
    .s1_tlast         (s1_tlast),
    .s1_tvalid        (s1_tvalid),
    .s1_tready        (s1_tready),
    .s_axis_tx_tready (s_axis_tx_tready),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .tx_src_dsc       (tx_src_dsc),
    .grant            (grant),
    .tlp_pktcount     (tlp_pktcount),
    .abort_count      (abort_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1;
    s0_tdata = '0; s0_tkeep = 8'hFF; s0_tlast = 1'b0; s0_tvalid = 1'b0;
    s1_tdata = '0; s1_tkeep = 8'hFF; s1_tlast = 1'b0; s1_tvalid = 1'b0;
    s_axis_tx_tready = 1'b1;

    // Reset state
    tick(); tick(); #1;
    check("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("rst_tdata", s_axis_tx_tdata, 64'd0);
    check("rst_tkeep", 64'(s_axis_tx_tkeep), 64'd0);
    check("rst_dsc", 64'(tx_src_dsc), 64'd0);
    check("rst_s0_tready", 64'(s0_tready), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_pktcount", 64'(tlp_pktcount), 64'd0);
    check("rst_abort_count", 64'(abort_count), 64'd0);
    sys_rst = 1'b0;

    // T1: s0 alone sends 3 beats
    tick();
    s0_tvalid = 1'b1; s0_tdata = 64'hA0A0_0000_0000_0000; s0_tkeep = 8'hFF; s0_tlast = 1'b0;
    #1;
    check("t1_latency_grant", 64'(grant), 64'd0);
    check("t1_latency_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    tick(); #1;
    check("t1_grant", 64'(grant), 64'd1);
    check("t1_beat0", s_axis_tx_tdata, 64'hA0A0_0000_0000_0000);
    check("t1_s0_tready", 64'(s0_tready), 64'd1);
    tick(); s0_tdata = 64'hA0A0_0000_0000_0001; s0_tkeep = 8'h0F; #1;
    check("t1_beat1", s_axis_tx_tdata, 64'hA0A0_0000_0000_0001);
    check("t1_keep1", 64'(s_axis_tx_tkeep), 64'h0F);
    tick(); s0_tdata = 64'hA0A0_0000_0000_0002; s0_tkeep = 8'hFF; s0_tlast = 1'b1; #1;
    check("t1_beat2", s_axis_tx_tdata, 64'hA0A0_0000_0000_0002);
    check("t1_last2", 64'(s_axis_tx_tlast), 64'd1);
    tick(); s0_tvalid = 1'b0; s0_tlast = 1'b0; #1;
    check("t1_idle_grant", 64'(grant), 64'd0);
    check("t1_pktcount", 64'(tlp_pktcount), 64'd1);

    // T3: s1 4 beats with core tready 1,0,0,1
    s1_tvalid = 1'b1; s1_tdata = 64'hC0; s1_tlast = 1'b0;
    tick(); #1;
    check("t3_grant", 64'(grant), 64'd2);
    check("t3_beat0", s_axis_tx_tdata, 64'hC0);
    check("t3_s1_tready_a", 64'(s1_tready), 64'd1);
    tick(); s1_tdata = 64'hC1; s_axis_tx_tready = 1'b0; #1;
    check("t3_bp_s1_tready", 64'(s1_tready), 64'd0);
    check("t3_bp_tvalid", 64'(s_axis_tx_tvalid), 64'd1);
    check("t3_bp_data", s_axis_tx_tdata, 64'hC1);
    tick(); #1;
    check("t3_bp2_data", s_axis_tx_tdata, 64'hC1);
    check("t3_bp2_stall", 64'(dut.stall_q), 64'd0);
    tick(); s_axis_tx_tready = 1'b1; #1;
    check("t3_resume_data", s_axis_tx_tdata, 64'hC1);
    check("t3_resume_s1_tready", 64'(s1_tready), 64'd1);
    tick(); s1_tdata = 64'hC2; #1;
    check("t3_beat2", s_axis_tx_tdata, 64'hC2);
    tick(); s1_tdata = 64'hC3; s1_tlast = 1'b1; #1;
    check("t3_beat3", s_axis_tx_tdata, 64'hC3);
    check("t3_last3", 64'(s_axis_tx_tlast), 64'd1);
    tick(); s1_tvalid = 1'b0; s1_tlast = 1'b0; #1;
    check("t3_idle_grant", 64'(grant), 64'd0);
    check("t3_pktcount", 64'(tlp_pktcount), 64'd2);
    check("t3_stall", 64'(dut.stall_q), 64'd0);

    // T2: both sources hold 2-beat TLPs; s0 wins (s1 went last)
    s0_tvalid = 1'b1; s0_tdata = 64'hE0; s0_tlast = 1'b0;
    s1_tvalid = 1'b1; s1_tdata = 64'hF0; s1_tlast = 1'b0;
    #1;
    check("t2_g0", 64'(grant), 64'd0);
    tick(); #1;
    check("t2_g1", 64'(grant), 64'd1);
    check("t2_e0", s_axis_tx_tdata, 64'hE0);
    check("t2_s1_held", 64'(s1_tready), 64'd0);
    tick(); s0_tdata = 64'hE1; s0_tlast = 1'b1; #1;
    check("t2_e1", s_axis_tx_tdata, 64'hE1);
    tick(); s0_tdata = 64'hE2; s0_tlast = 1'b0; #1;
    check("t2_g2", 64'(grant), 64'd0);
    check("t2_gap_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    tick(); #1;
    check("t2_g3", 64'(grant), 64'd2);
    check("t2_f0", s_axis_tx_tdata, 64'hF0);
    check("t2_s0_held", 64'(s0_tready), 64'd0);
    tick(); s1_tdata = 64'hF1; s1_tlast = 1'b1; #1;
    check("t2_f1", s_axis_tx_tdata, 64'hF1);
    tick(); s1_tvalid = 1'b0; s1_tlast = 1'b0; #1;
    check("t2_g4", 64'(grant), 64'd0);
    tick(); #1;
    check("t2_g5", 64'(grant), 64'd1);
    check("t2_e2", s_axis_tx_tdata, 64'hE2);
    tick(); s0_tdata = 64'hE3; s0_tlast = 1'b1; #1;
    check("t2_e3", s_axis_tx_tdata, 64'hE3);
    tick(); s0_tvalid = 1'b0; s0_tlast = 1'b0; #1;
    check("t2_pktcount", 64'(tlp_pktcount), 64'd5);

    // T4: s0 sends one beat then stalls for TIMEOUT=4 cycles
    s0_tvalid = 1'b1; s0_tdata = 64'h4040; s0_tlast = 1'b0;
    tick(); #1;
    check("t4_beat0", s_axis_tx_tdata, 64'h4040);
    tick(); s0_tvalid = 1'b0; #1;
    check("t4_stall_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("t4_stall_grant", 64'(grant), 64'd1);
    tick(); tick(); tick(); #1;
    check("t4_pre_abort_dsc", 64'(tx_src_dsc), 64'd0);
    tick(); s_axis_tx_tready = 1'b0; #1;
    check("t4_abort_tvalid", 64'(s_axis_tx_tvalid), 64'd1);
    check("t4_abort_tlast", 64'(s_axis_tx_tlast), 64'd1);
    check("t4_abort_dsc", 64'(tx_src_dsc), 64'd1);
    check("t4_abort_tkeep", 64'(s_axis_tx_tkeep), 64'hFF);
    check("t4_abort_tdata", s_axis_tx_tdata, 64'd0);
    check("t4_abort_s0_tready", 64'(s0_tready), 64'd0);
    check("t4_abort_count", 64'(abort_count), 64'd1);
    tick(); s_axis_tx_tready = 1'b1; #1;
    check("t4_abort_hold_dsc", 64'(tx_src_dsc), 64'd1);
    tick(); s0_tvalid = 1'b1; s0_tdata = 64'hDEAD; s0_tlast = 1'b0; #1;
    check("t4_drain_s0_tready", 64'(s0_tready), 64'd1);
    check("t4_drain_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("t4_drain_grant", 64'(grant), 64'd0);
    tick(); s0_tdata = 64'hBEEF; s0_tlast = 1'b1; #1;
    check("t4_drain2_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("t4_drain2_s0_tready", 64'(s0_tready), 64'd1);
    tick(); s0_tvalid = 1'b0; s0_tlast = 1'b0; #1;
    check("t4_post_s0_tready", 64'(s0_tready), 64'd0);
    check("t4_pktcount", 64'(tlp_pktcount), 64'd5);
    check("t4_abort_count_final", 64'(abort_count), 64'd1);

    // T5: reset on second beat of an s1 packet
    s1_tvalid = 1'b1; s1_tdata = 64'h5150; s1_tlast = 1'b0;
    tick(); #1;
    check("t5_beat0", s_axis_tx_tdata, 64'h5150);
    tick(); s1_tdata = 64'h5151; sys_rst = 1'b1; #1;
    check("t5_inrst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("t5_inrst_tdata", s_axis_tx_tdata, 64'd0);
    check("t5_inrst_s1_tready", 64'(s1_tready), 64'd0);
    tick(); sys_rst = 1'b0; #1;
    check("t5_post_grant", 64'(grant), 64'd0);
    check("t5_post_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    check("t5_post_pktcount", 64'(tlp_pktcount), 64'd0);
    check("t5_post_abort_count", 64'(abort_count), 64'd0);
    s0_tvalid = 1'b1; s0_tdata = 64'h5000; s0_tlast = 1'b1;
    s1_tdata = 64'h5150;
    tick(); #1;
    check("t5_tie_grant", 64'(grant), 64'd1);
    check("t5_tie_data", s_axis_tx_tdata, 64'h5000);
    tick(); s0_tvalid = 1'b0; s0_tlast = 1'b0; #1;
    check("t5_pktcount", 64'(tlp_pktcount), 64'd1);
    tick(); #1;
    check("t5_s1_grant", 64'(grant), 64'd2);
    tick(); s1_tdata = 64'h5151; s1_tlast = 1'b1; #1;
    check("t5_s1_last", s_axis_tx_tdata, 64'h5151);
    tick(); s1_tvalid = 1'b0; s1_tlast = 1'b0; #1;
    check("t5_pktcount2", 64'(tlp_pktcount), 64'd2);

    // T6: 256 single-beat s1 packets from reset; counter wraps to 0
    sys_rst = 1'b1;
    tick(); sys_rst = 1'b0;
    s1_tvalid = 1'b1; s1_tlast = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s1_tdata = 64'(i);
      #1;
      check("t6_gap_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
      check("t6_gap_count", 64'(tlp_pktcount), 64'(i % 256));
      tick(); #1;
      check("t6_beat_grant", 64'(grant), 64'd2);
      check("t6_beat_data", s_axis_tx_tdata, 64'(i));
      check("t6_beat_last", 64'(s_axis_tx_tlast), 64'd1);
      tick();
    end
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    #1;
    check("t6_wrap", 64'(tlp_pktcount), 64'd0);
    check("t6_abort_count", 64'(abort_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
